// File: rtl/vex_bus_slave_model.sv
// vex_bus_slave_model
// Legal-behaviour cmd/rsp slave for VexRiscv formal and simulation harnesses.
// Free random inputs from the solver are gated so the core only sees legal
// handshakes: bounded outstanding responses, in-order, never zero-latency.
// Optional macro VEXRISCV_BUS_FAIRNESS_EN forces cmd_ready / rsp_valid once a
// stall reaches MAX_STALL cycles; without it the stall counters and fair_ok
// still run so the wrapper can restrict or observe them.
module vex_bus_slave_model #(
    parameter int DATA_W       = 32,
    parameter int MAX_PENDING  = 4,
    parameter int PEND_W       = $clog2(MAX_PENDING + 1),
    parameter int MAX_STALL    = 3,
    parameter int RSP_ON_WRITE = 0,
    parameter int ALLOW_ERROR  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              cmd_wr,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    input  logic              rand_cmd_ready,
    input  logic              rand_rsp_valid,
    input  logic              rand_rsp_error,
    input  logic [DATA_W-1:0] rand_rsp_data,
    output logic [PEND_W-1:0] pending,
    output logic              proto_err,
    output logic              fair_ok
);

    // Stall counters must be able to hold MAX_STALL+1 (the saturation value).
    localparam int                STALL_W   = $clog2(MAX_STALL + 2);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);
    localparam logic [STALL_W-1:0] STALL_SAT = STALL_W'(MAX_STALL + 1);
    localparam logic [PEND_W-1:0]  PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0]  PEND_ONE  = PEND_W'(1);

    logic               in_rst;
    logic               force_cmd;
    logic               force_rsp;
    logic               cmd_fire;
    logic               exp_rsp;
    logic               rsp_inc;
    logic               not_full;
    logic               has_pend;
    logic [PEND_W-1:0]  pend_nxt;
    logic [STALL_W-1:0] cmd_stall;
    logic [STALL_W-1:0] rsp_wait;
    logic [STALL_W-1:0] cmd_stall_nxt;
    logic [STALL_W-1:0] rsp_wait_nxt;
    logic               cur_stall;
    logic               prev_stall;
    logic               prev_wr;
    logic               proto_hit;

    assign in_rst   = !reset;
    assign not_full = (pending < PEND_MAX);
    assign has_pend = (pending != '0);

`ifdef VEXRISCV_BUS_FAIRNESS_EN
    // Force progress once a wait has lasted exactly MAX_STALL cycles.
    assign force_cmd = (cmd_stall == STALL_MAX);
    assign force_rsp = (rsp_wait == STALL_MAX);
`else
    assign force_cmd = 1'b0;
    assign force_rsp = 1'b0;
`endif

    // Handshake gating: full blocks acceptance even when force_cmd is set,
    // and responses only exist while something is outstanding.
    always_comb begin
        cmd_ready = !in_rst && not_full && (rand_cmd_ready || force_cmd);
        rsp_valid = !in_rst && has_pend && (rand_rsp_valid || force_rsp);
        rsp_data  = rsp_valid ? rand_rsp_data : '0;
        rsp_error = rsp_valid && (ALLOW_ERROR != 0) && rand_rsp_error;
    end

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign exp_rsp   = !cmd_wr || (RSP_ON_WRITE != 0);
    assign rsp_inc   = cmd_fire && exp_rsp;
    assign cur_stall = cmd_valid && !cmd_ready;

    // Outstanding count: accept and retire in the same cycle cancel out.
    always_comb begin
        pend_nxt = pending;
        if (rsp_inc && !rsp_valid)
            pend_nxt = pending + PEND_ONE;
        else if (!rsp_inc && rsp_valid)
            pend_nxt = pending - PEND_ONE;
    end

    // Stall counters: count consecutive wait cycles, saturate one past the bound.
    always_comb begin
        cmd_stall_nxt = '0;
        if (cur_stall)
            cmd_stall_nxt = (cmd_stall == STALL_SAT) ? STALL_SAT : cmd_stall + STALL_W'(1);
        rsp_wait_nxt = '0;
        if (has_pend && !rsp_valid)
            rsp_wait_nxt = (rsp_wait == STALL_SAT) ? STALL_SAT : rsp_wait + STALL_W'(1);
    end

    // A stalled command must stay valid with the same direction next cycle.
    assign proto_hit = prev_stall && (!cmd_valid || (cmd_wr != prev_wr));

    assign fair_ok = (cmd_stall <= STALL_MAX) && (rsp_wait <= STALL_MAX);

    // State update; reset drops every outstanding response.
    always_ff @(posedge clock) begin
        if (in_rst) begin
            pending    <= '0;
            cmd_stall  <= '0;
            rsp_wait   <= '0;
            prev_stall <= 1'b0;
            prev_wr    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            pending    <= pend_nxt;
            cmd_stall  <= cmd_stall_nxt;
            rsp_wait   <= rsp_wait_nxt;
            prev_stall <= cur_stall;
            prev_wr    <= cmd_wr;
            if (proto_hit)
                proto_err <= 1'b1;
        end
    end

endmodule
